wfg_drive_spi_mc: RTL and testbench
===================================

Name: wfg_drive_spi_mc

Overview:
Parametrised SPI output stage for the waveform generator. It succeeds the fixed 32-bit, single-CS, mode-0 SPI driver. Accepts samples over a valid/ready stream and serialises each one onto a shared SCLK/SDO pair. Adds programmable word length, clock divider, CPOL, bit order, inter-word gap, and round-robin chip-select rotation across NUM_CS channels. Sits between the WFG sample core and the mprj_io pads.

Parameters:
DATA_W, 32, maximum word width in bits (≥2)
NUM_CS, 4, number of chip-select outputs (1..8)
DIV_W, 8, width of clock divider config
GAP_W, 8, width of inter-word gap config

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous reset, active-high
ctrl_en_i  in  1  enable; gates acceptance of new words
cfg_cpol_i  in  1  SCLK idle level
cfg_lsbfirst_i  in  1  1 = LSB first, 0 = MSB first
cfg_div_i  in  DIV_W  SCLK half-period = cfg_div_i+1 clocks
cfg_len_i  in  $clog2(DATA_W)  word length minus 1
cfg_gap_i  in  GAP_W  CS-high gap = cfg_gap_i+1 clocks
cfg_cs_mask_i  in  NUM_CS  channels taking part in rotation
s_valid_i  in  1  sample valid
s_data_i  in  DATA_W  sample, right-aligned
s_ready_o  out  1  sample accepted when s_valid_i & s_ready_o
sclk_o  out  1  SPI clock
cs_n_o  out  NUM_CS  active-low chip selects
sdo_o  out  1  serial data
busy_o  out  1  high in any state other than IDLE
word_done_o  out  1  one-cycle pulse when CS deasserts after a word

Behaviour:
- Reset values: sclk_o=0, cs_n_o all 1, sdo_o=0, s_ready_o=0, busy_o=0, word_done_o=0, last channel index=NUM_CS-1, FSM=IDLE.
- Reset asserted mid-word forces these values immediately. No completion pulse is generated.
- All outputs are registered.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - sclk_o follows cfg_cpol_i.
  - s_ready_o = ctrl_en_i & (cfg_cs_mask_i != 0).
  - On handshake, latch data, len, lsbfirst, cpol, div and gap. Later config changes do not affect the word in flight.
  - Select the next channel: the lowest set mask bit strictly above the last index, wrapping to bit 0. After reset this is the lowest set bit.
  - Move to SETUP. s_ready_o drops the next cycle.
- SETUP:
  - The selected cs_n_o bit goes low and sdo_o drives the first bit.
  - Lasts h = div+1 clocks.
- SHIFT:
  - sclk_o toggles every h clocks.
  - Leading edge (away from CPOL) is the sample edge; sdo_o is stable across it.
  - Trailing edge presents the next bit.
  - Exactly len+1 leading edges, then the final trailing edge returns sclk_o to CPOL. Go to HOLD.
- HOLD: h clocks with CS still low.
- At the end of HOLD: CS rises, word_done_o pulses for 1 cycle, and the FSM enters GAP.
- GAP: gap+1 clocks with all CS high, then IDLE.
- Word length and bit order:
  - Bits sent = len+1. A len field value ≥ DATA_W-1 clamps to DATA_W.
  - MSB first: bit len down to 0. LSB first: bit 0 up to len.
  - Bits above len are ignored.
- Word timing: IDLE handshake to word_done_o = 1 + h·(2·(len+1)+2) clocks.
- ctrl_en_i falling mid-word: the current word completes normally, and no further words are accepted.
- cfg_cs_mask_i changing mid-word: no effect on the active CS. The next selection uses the new mask.
- Mask = 0 in IDLE: s_ready_o stays 0 and no transfer starts.
- sdo_o holds the last bit after a word and returns to 0 on the next SETUP-free IDLE.

Optional Feature:
WFG_SPI_SDI_EN
- Defined: adds ports sdi_i (in, 1), m_data_o (out, DATA_W) and m_valid_o (out, 1).
  - sdi_i is sampled on each leading SCLK edge into a shift register, using the same bit order as transmit.
  - At word_done_o, m_data_o is updated with the received word right-aligned (upper bits 0) and m_valid_o pulses 1 cycle.
  - No backpressure on the receive side.
  - Reset values: m_data_o=0, m_valid_o=0.
- Undefined: these ports and their logic do not exist.

Test Plan:
1. DATA_W=32, div=0, len=31, mask=0001, cpol=0, MSB first; send 25094 then 46345 -> cs_n_o[0] low per word, 32 rising sclk edges each, deserialised words 25094 and 46345, two word_done_o pulses, 67 clocks from handshake to done.
2. mask=1010, send 3 words -> CS order cs_n_o[1], cs_n_o[3], cs_n_o[1], never two CS low together.
3. len=7, lsbfirst=1, data=0xA53C -> exactly 8 leading edges, sdo bits 0,0,1,1,1,1,0,0, upper bits ignored.
4. cpol=1, div=3 -> sclk_o idle high, high/low phases of exactly 4 clocks each, word time 1+4·(2·(len+1)+2).
5. Drop ctrl_en_i during bit 10 -> word finishes all bits, word_done_o pulses, s_ready_o stays 0. Separately, mask=0 with s_valid_i=1 -> s_ready_o=0 and no CS activity.
6. Assert wb_rst_i mid-SHIFT -> cs_n_o all 1 and sclk_o=0 with no clock edge required, no word_done_o pulse. After release, the first word goes to the lowest mask bit.

Source files
------------

// File: rtl/wfg_drive_spi_mc.sv
// SPI output stage: valid/ready samples serialised onto SCLK/SDO with round-robin CS.
// Define WFG_SPI_SDI_EN to add the SDI receive path (sdi_i, m_data_o, m_valid_o).
module wfg_drive_spi_mc #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int GAP_W  = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      ctrl_en_i,
  input  logic                      cfg_cpol_i,
  input  logic                      cfg_lsbfirst_i,
  input  logic [DIV_W-1:0]          cfg_div_i,
  input  logic [$clog2(DATA_W)-1:0] cfg_len_i,
  input  logic [GAP_W-1:0]          cfg_gap_i,
  input  logic [NUM_CS-1:0]         cfg_cs_mask_i,
  input  logic                      s_valid_i,
  input  logic [DATA_W-1:0]         s_data_i,
  output logic                      s_ready_o,
  output logic                      sclk_o,
  output logic [NUM_CS-1:0]         cs_n_o,
  output logic                      sdo_o,
  output logic                      busy_o,
  output logic                      word_done_o
`ifdef WFG_SPI_SDI_EN
  ,
  input  logic                      sdi_i,
  output logic [DATA_W-1:0]         m_data_o,
  output logic                      m_valid_o
`endif
);
  localparam int LEN_W = $clog2(DATA_W);
  localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state;

  logic [DATA_W-1:0] data_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              lsb_reg;
  logic              cpol_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [GAP_W-1:0]  gap_reg;
  logic [DIV_W-1:0]  tick;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  last_idx;
  logic [LEN_W-1:0]  bit_num;

  logic              accept;
  logic              tick_end;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  nxt_num;
  logic [LEN_W-1:0]  nxt_idx;
  logic [IDX_W-1:0]  next_cs;

  assign accept   = (state == IDLE) && s_valid_i && s_ready_o;
  assign tick_end = (tick == div_reg);
  assign len_eff  = (cfg_len_i >= LEN_W'(DATA_W - 1)) ? LEN_W'(DATA_W - 1) : cfg_len_i;
  assign nxt_num  = bit_num + 1'b1;
  assign nxt_idx  = lsb_reg ? nxt_num : (len_reg - nxt_num);

  // Search starts just above the last channel and wraps; the last channel itself is tried last.
  always_comb begin
    logic found;
    logic [IDX_W-1:0] cand;
    found   = 1'b0;
    next_cs = last_idx;
    cand    = '0;
    for (int k = 1; k <= NUM_CS; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_CS);
      if (!found && cfg_cs_mask_i[cand]) begin
        found   = 1'b1;
        next_cs = cand;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      sclk_o      <= 1'b0;
      cs_n_o      <= '1;
      sdo_o       <= 1'b0;
      s_ready_o   <= 1'b0;
      busy_o      <= 1'b0;
      word_done_o <= 1'b0;
      last_idx    <= IDX_W'(NUM_CS - 1);
      data_reg    <= '0;
      len_reg     <= '0;
      lsb_reg     <= 1'b0;
      cpol_reg    <= 1'b0;
      div_reg     <= '0;
      gap_reg     <= '0;
      tick        <= '0;
      gap_cnt     <= '0;
      bit_num     <= '0;
    end else begin
      word_done_o <= 1'b0;
      case (state)
        IDLE: begin
          sclk_o <= cfg_cpol_i;
          if (accept) begin
            s_ready_o <= 1'b0;
            busy_o    <= 1'b1;
            data_reg  <= s_data_i;
            len_reg   <= len_eff;
            lsb_reg   <= cfg_lsbfirst_i;
            cpol_reg  <= cfg_cpol_i;
            div_reg   <= cfg_div_i;
            gap_reg   <= cfg_gap_i;
            last_idx  <= next_cs;
            cs_n_o    <= ~(NUM_CS'(1) << next_cs);
            sdo_o     <= cfg_lsbfirst_i ? s_data_i[0] : s_data_i[len_eff];
            bit_num   <= '0;
            tick      <= '0;
            state     <= SETUP;
          end else begin
            s_ready_o <= ctrl_en_i && (cfg_cs_mask_i != '0);
            sdo_o     <= 1'b0;
          end
        end
        SETUP: begin
          tick <= tick_end ? '0 : tick + 1'b1;
          if (tick_end) state <= SHIFT;
        end
        SHIFT: begin
          tick <= tick_end ? '0 : tick + 1'b1;
          if (tick_end) begin
            sclk_o <= ~sclk_o;
            // Trailing edge (sclk currently away from idle) advances the data bit.
            if (sclk_o != cpol_reg) begin
              if (bit_num == len_reg) begin
                state <= HOLD;
              end else begin
                bit_num <= nxt_num;
                sdo_o   <= data_reg[nxt_idx];
              end
            end
          end
        end
        HOLD: begin
          tick <= tick_end ? '0 : tick + 1'b1;
          if (tick_end) begin
            cs_n_o      <= '1;
            word_done_o <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == gap_reg) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            s_ready_o <= ctrl_en_i && (cfg_cs_mask_i != '0);
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WFG_SPI_SDI_EN
  logic [DATA_W-1:0] rx_reg;
  logic [LEN_W-1:0]  cur_idx;

  assign cur_idx = lsb_reg ? bit_num : (len_reg - bit_num);

  // Received bits land at the same index they were sent from, so the word is right-aligned.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_reg    <= '0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
    end else begin
      m_valid_o <= 1'b0;
      if (accept)
        rx_reg <= '0;
      else if (state == SHIFT && tick_end && sclk_o == cpol_reg)
        rx_reg[cur_idx] <= sdi_i;
      if (state == HOLD && tick_end) begin
        m_data_o  <= rx_reg;
        m_valid_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// Self-checking bench for wfg_drive_spi_mc: directed cases plus randomized words vs a behavioural model.
module tb_wfg_drive_spi_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_en;
  logic        cfg_cpol;
  logic        cfg_lsbfirst;
  logic [7:0]  cfg_div;
  logic [4:0]  cfg_len;
  logic [7:0]  cfg_gap;
  logic [3:0]  cfg_mask;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        sclk;
  logic [3:0]  cs_n;
  logic        sdo;
  logic        busy;
  logic        word_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_last;

  wfg_drive_spi_mc #(.DATA_W(32), .NUM_CS(4), .DIV_W(8), .GAP_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ctrl_en_i(ctrl_en), .cfg_cpol_i(cfg_cpol),
    .cfg_lsbfirst_i(cfg_lsbfirst), .cfg_div_i(cfg_div), .cfg_len_i(cfg_len),
    .cfg_gap_i(cfg_gap), .cfg_cs_mask_i(cfg_mask), .s_valid_i(s_valid), .s_data_i(s_data),
    .s_ready_o(s_ready), .sclk_o(sclk), .cs_n_o(cs_n), .sdo_o(sdo), .busy_o(busy),
    .word_done_o(word_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next channel: first enabled index above the previous one, else the lowest enabled index.
  function automatic int pick_channel(input logic [3:0] m, input int last);
    int q[$];
    int res;
    for (int i = 0; i < 4; i++) if (m[i]) q.push_back(i);
    res = q[0];
    for (int j = q.size() - 1; j >= 0; j--) if (q[j] > last) res = q[j];
    return res;
  endfunction

  task automatic run_word(input logic [31:0] data, input int len, input bit lsb, input bit cpol,
                          input int div, input int gap, input logic [3:0] mask,
                          input int drop_bit, input bit scramble);
    int h, n, exp_ch, ch, lead, low_cyc, multi, idle_busy, t_prev, min_iv, max_iv, c0, lat, lows;
    logic [63:0] rx, exp_word;
    logic prev_sclk;
    bit got_hs, got_done;
    h = div + 1; n = len + 1;
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    ctrl_en = 1; cfg_cpol = cpol; cfg_lsbfirst = lsb; cfg_div = 8'(div);
    cfg_len = 5'(len); cfg_gap = 8'(gap); cfg_mask = mask;
    @(negedge clk); @(negedge clk);
    s_valid = 1; s_data = data;
    got_hs = 0; c0 = 0;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin got_hs = 1; c0 = cyc; break; end
      @(negedge clk);
    end
    if (!got_hs) begin
      check_eq("hs_timeout", 64'(s_ready), 64'd1);
      s_valid = 0;
      return;
    end
    check_eq("sclk_idle", 64'(sclk), 64'(cpol));
    exp_ch = pick_channel(mask, model_last);
    model_last = exp_ch;
    exp_word = 64'(data) & ((64'd1 << n) - 1);
    ch = -1; lead = 0; low_cyc = 0; multi = 0; idle_busy = 0; t_prev = -1;
    min_iv = 1 << 30; max_iv = 0; lat = -1; rx = 0; prev_sclk = cpol; got_done = 0;
    for (int i = 0; i < 1 + h * (2 * n + 2) + 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        s_valid = 0;
        if (scramble) begin
          cfg_mask = 4'($urandom_range(1, 15)); cfg_len = 5'($urandom);
          cfg_div = 8'($urandom_range(0, 3)); cfg_cpol = 1'($urandom);
          cfg_lsbfirst = 1'($urandom); cfg_gap = 8'($urandom_range(0, 3));
        end
      end
      if (word_done) begin got_done = 1; lat = cyc - c0; break; end
      if (!busy) idle_busy++;
      lows = 0;
      for (int b = 0; b < 4; b++) if (!cs_n[b]) begin lows++; ch = b; end
      if (lows > 0) low_cyc++;
      if (lows > 1) multi++;
      if (sclk != prev_sclk) begin
        if (t_prev >= 0) begin
          if (cyc - t_prev < min_iv) min_iv = cyc - t_prev;
          if (cyc - t_prev > max_iv) max_iv = cyc - t_prev;
        end
        t_prev = cyc;
        if (sclk != cpol) begin
          lead++;
          if (lsb) rx[lead-1] = sdo; else rx = {rx[62:0], sdo};
          if (lead == drop_bit) ctrl_en = 0;
        end
        prev_sclk = sclk;
      end
    end
    if (!got_done) begin
      check_eq("done_timeout", 64'(word_done), 64'd1);
      return;
    end
    check_eq("latency", 64'(lat), 64'(1 + h * (2 * n + 2)));
    check_eq("cs_channel", 64'(ch), 64'(exp_ch));
    check_eq("cs_low_cycles", 64'(low_cyc), 64'(h * (2 * n + 2)));
    check_eq("cs_overlap", 64'(multi), 64'd0);
    check_eq("lead_edges", 64'(lead), 64'(n));
    check_eq("rx_word", rx, exp_word);
    check_eq("phase_min", 64'(min_iv), 64'(h));
    check_eq("phase_max", 64'(max_iv), 64'(h));
    check_eq("busy_in_word", 64'(idle_busy), 64'd0);
    check_eq("sclk_at_done", 64'(sclk), 64'(cpol));
    check_eq("cs_at_done", 64'(cs_n), 64'hF);
    $display("word data=%08h len=%0d lsb=%0d cpol=%0d div=%0d mask=%b ch=%0d rx=%0h lat=%0d",
             data, len, lsb, cpol, div, mask, ch, rx, lat);
    @(negedge clk);
    check_eq("done_width", 64'(word_done), 64'd0);
  endtask

  initial begin
    rst = 1; ctrl_en = 0; cfg_cpol = 0; cfg_lsbfirst = 0; cfg_div = 0; cfg_len = 31;
    cfg_gap = 0; cfg_mask = 4'b0001; s_valid = 0; s_data = 0;
    model_last = 3;
    #1;
    check_eq("rst_sclk", 64'(sclk), 64'd0);
    check_eq("rst_cs", 64'(cs_n), 64'hF);
    check_eq("rst_sdo", 64'(sdo), 64'd0);
    check_eq("rst_ready", 64'(s_ready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(word_done), 64'd0);
    repeat (3) @(negedge clk);
    rst = 0;

    // Full 32-bit MSB-first words on channel 0.
    run_word(32'd25094, 31, 0, 0, 0, 0, 4'b0001, -1, 0);
    run_word(32'd46345, 31, 0, 0, 0, 0, 4'b0001, -1, 0);
    // Rotation over a sparse mask.
    for (int i = 0; i < 3; i++) run_word($urandom, 15, 0, 0, 0, 1, 4'b1010, -1, 0);
    // Short LSB-first word, upper bits ignored.
    run_word(32'h0000A53C, 7, 1, 0, 0, 0, 4'b1010, -1, 0);
    // Idle-high clock with a slow divider.
    run_word($urandom, 12, 0, 1, 3, 2, 4'b0100, -1, 0);

    // Enable falls during bit 10: word completes, nothing further accepted.
    run_word($urandom, 20, 0, 0, 1, 0, 4'b0011, 10, 0);
    s_valid = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_eq("ready_after_drop", 64'(s_ready), 64'd0);
      check_eq("cs_after_drop", 64'(cs_n), 64'hF);
    end
    s_valid = 0;
    $display("enable drop: no further words accepted");

    // Empty mask blocks transfers.
    ctrl_en = 1; cfg_mask = 4'b0000;
    @(negedge clk); @(negedge clk);
    s_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("ready_mask0", 64'(s_ready), 64'd0);
      check_eq("cs_mask0", 64'(cs_n), 64'hF);
    end
    s_valid = 0;
    $display("mask zero: no transfer started");

    // Randomized words, with config scrambled while each word is in flight.
    for (int t = 0; t < 14; t++)
      run_word($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               4'($urandom_range(1, 15)), -1, 1'($urandom));

    // Asynchronous reset in the middle of SHIFT.
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    ctrl_en = 1; cfg_cpol = 1; cfg_lsbfirst = 0; cfg_div = 0; cfg_len = 31; cfg_mask = 4'b1100;
    @(negedge clk); @(negedge clk);
    s_valid = 1; s_data = $urandom;
    @(negedge clk);
    s_valid = 0;
    repeat (20) @(negedge clk);
    check_eq("busy_before_rst", 64'(busy), 64'd1);
    rst = 1;
    #1;
    check_eq("midrst_cs", 64'(cs_n), 64'hF);
    check_eq("midrst_sclk", 64'(sclk), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_done", 64'(word_done), 64'd0);
    end
    rst = 0;
    model_last = 3;
    $display("reset mid-word: outputs forced idle");
    run_word($urandom, 9, 0, 0, 0, 0, 4'b1010, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
